// File: rtl/analysis_pkg.sv
// Shared constants and types for the spectral analysis chain.
package analysis_pkg;
    localparam int unsigned NFFT         = 1024;
    localparam int unsigned FFT_SAMPLE_W = 24;
    localparam int unsigned BIN_W        = $clog2(NFFT);

    typedef logic [BIN_W-1:0] bin_t;

    // Matches the FFT output word: im in the upper half, re in the lower half.
    typedef struct packed {
        logic signed [FFT_SAMPLE_W-1:0] im;
        logic signed [FFT_SAMPLE_W-1:0] re;
    } cplx_t;
endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream style valid/ready/data bundle.
interface Axis_If #(
    parameter int unsigned W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport Master (output valid, output data, input ready);
    modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/cmag_sq.sv
// Two-stage signed re^2 + im^2 with clock enable, right shift and saturation.
module cmag_sq #(
    parameter int unsigned IN_W  = 24,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SHIFT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic signed [IN_W-1:0] re,
    input  logic signed [IN_W-1:0] im,
    output logic [OUT_W-1:0]       power
);
    localparam int unsigned SW = 2 * IN_W;
    localparam int unsigned WW = (SW > OUT_W) ? SW : OUT_W;

    // Squares are non-negative and below 2^(2*IN_W-1), so the sign bit is dropped.
    logic [SW-2:0]    rr;
    logic [SW-2:0]    ii;
    logic [SW-1:0]    sum;
    logic [WW-1:0]    shifted;
    logic [OUT_W-1:0] power_n;

    always_comb begin
        sum     = {1'b0, rr} + {1'b0, ii};
        shifted = WW'(sum) >> SHIFT;
        power_n = (shifted > WW'({OUT_W{1'b1}})) ? '1 : shifted[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr    <= '0;
            ii    <= '0;
            power <= '0;
        end else if (en) begin
            rr    <= (SW-1)'(re * re);
            ii    <= (SW-1)'(im * im);
            power <= power_n;
        end
    end
endmodule

// File: rtl/fft_power.sv
// Per-bin power of the FFT spectrum with half-spectrum drop and backpressure.
// Optional peak tracker enabled by defining FFT_POWER_PEAK_EN.
module fft_power #(
    parameter int unsigned NFFT          = analysis_pkg::NFFT,
    parameter int unsigned IN_W          = analysis_pkg::FFT_SAMPLE_W,
    parameter int unsigned OUT_W         = 32,
    parameter int unsigned SHIFT         = 16,
    parameter int unsigned HALF_SPECTRUM = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    Axis_If.Slave                    din,
    Axis_If.Master                   dout,
    output logic [$clog2(NFFT)-1:0]  dout_bin,
    output logic                     dout_last
`ifdef FFT_POWER_PEAK_EN
    ,
    output logic [$clog2(NFFT)-1:0]  peak_bin,
    output logic [OUT_W-1:0]         peak_power,
    output logic                     peak_valid
`endif
);
    localparam int unsigned BW = $clog2(NFFT);
    localparam logic [BW-1:0] LAST_BIN = (HALF_SPECTRUM != 0) ? BW'(NFFT/2 - 1) : BW'(NFFT - 1);

    logic                   en;
    logic                   keep;
    logic [BW-1:0]          cnt;
    logic signed [IN_W-1:0] re1;
    logic signed [IN_W-1:0] im1;
    logic                   v1, v2, v3;
    logic [BW-1:0]          bin1, bin2, bin3;
    logic                   last1, last2, last3;
    logic [OUT_W-1:0]       power;

    assign en        = !v3 || dout.ready;
    assign keep      = (HALF_SPECTRUM == 0) || !cnt[BW-1];
    assign din.ready = en;

    // Upper-half bins are still consumed; only their valid bit is suppressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            re1   <= '0;
            im1   <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            bin1  <= '0;
            bin2  <= '0;
            bin3  <= '0;
            last1 <= 1'b0;
            last2 <= 1'b0;
            last3 <= 1'b0;
        end else if (en) begin
            if (din.valid) begin
                cnt <= cnt + 1'b1;
            end
            v1    <= din.valid && keep;
            re1   <= din.data[IN_W-1:0];
            im1   <= din.data[2*IN_W-1:IN_W];
            bin1  <= cnt;
            last1 <= (cnt == LAST_BIN);
            v2    <= v1;
            bin2  <= bin1;
            last2 <= last1;
            v3    <= v2;
            bin3  <= bin2;
            last3 <= last2;
        end
    end

    cmag_sq #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_cmag_sq (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .re    (re1),
        .im    (im1),
        .power (power)
    );

    assign dout.valid = v3;
    assign dout.data  = power;
    assign dout_bin   = bin3;
    assign dout_last  = last3;

`ifdef FFT_POWER_PEAK_EN
    logic [OUT_W-1:0] trk_power;
    logic [BW-1:0]    trk_bin;
    logic             trk_any;
    logic             take;
    logic [OUT_W-1:0] cand_power;
    logic [BW-1:0]    cand_bin;

    // Strict compare on ascending bins keeps the lowest bin on ties; DC never qualifies.
    always_comb begin
        take       = (bin3 != '0) && (!trk_any || (power > trk_power));
        cand_power = take ? power : trk_power;
        cand_bin   = take ? bin3  : trk_bin;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trk_power  <= '0;
            trk_bin    <= '0;
            trk_any    <= 1'b0;
            peak_bin   <= '0;
            peak_power <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (v3 && dout.ready) begin
                if (last3) begin
                    peak_power <= cand_power;
                    peak_bin   <= cand_bin;
                    peak_valid <= 1'b1;
                    trk_power  <= '0;
                    trk_bin    <= '0;
                    trk_any    <= 1'b0;
                end else if (take) begin
                    trk_power <= power;
                    trk_bin   <= bin3;
                    trk_any   <= 1'b1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_fft_power.sv
// Self-checking bench for fft_power: two instances (SHIFT=0 and SHIFT=16) run in lockstep.
// Peak checks are compiled in when FFT_POWER_PEAK_EN is defined.
module tb_fft_power;
    import analysis_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    Axis_If #(.W(48)) din_a ();
    Axis_If #(.W(32)) dout_a ();
    Axis_If #(.W(48)) din_b ();
    Axis_If #(.W(32)) dout_b ();

    bin_t bin_a, bin_b;
    logic last_a, last_b;
`ifdef FFT_POWER_PEAK_EN
    bin_t        pbin_a, pbin_b;
    logic [31:0] pp_a, pp_b;
    logic        pv_a, pv_b;
`endif

    assign din_b.valid  = din_a.valid;
    assign din_b.data   = din_a.data;
    assign dout_b.ready = dout_a.ready;

    fft_power #(.NFFT(1024), .IN_W(24), .OUT_W(32), .SHIFT(0), .HALF_SPECTRUM(1)) dut_a (
        .clk(clk), .reset(reset), .din(din_a), .dout(dout_a), .dout_bin(bin_a), .dout_last(last_a)
`ifdef FFT_POWER_PEAK_EN
        , .peak_bin(pbin_a), .peak_power(pp_a), .peak_valid(pv_a)
`endif
    );

    fft_power #(.NFFT(1024), .IN_W(24), .OUT_W(32), .SHIFT(16), .HALF_SPECTRUM(1)) dut_b (
        .clk(clk), .reset(reset), .din(din_b), .dout(dout_b), .dout_bin(bin_b), .dout_last(last_b)
`ifdef FFT_POWER_PEAK_EN
        , .peak_bin(pbin_b), .peak_power(pp_b), .peak_valid(pv_b)
`endif
    );

    typedef struct {
        logic        in_hs, out_hs, valid, dready, last;
        logic [31:0] d0, d16;
        bin_t        bin;
`ifdef FFT_POWER_PEAK_EN
        logic        pv;
        bin_t        pbin0, pbin16;
        logic [31:0] pp0, pp16;
`endif
    } obs_t;

    typedef struct {
        logic [31:0] d0, d16;
        bin_t        bin;
        logic        last;
    } exp_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned mbin     = 0;
    exp_t        exp_q[$];

    // Reference power: exact integer square sum, shifted, clipped to 32 bits.
    function automatic logic [31:0] ref_pow(input cplx_t c, input int unsigned sh);
        longint re = $signed(c.re);
        longint im = $signed(c.im);
        longint unsigned p = longint'(re * re + im * im);
        p = p >> sh;
        if (p > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        return p[31:0];
    endfunction

    // Every accepted sample advances the frame position; only the lower half is emitted.
    function automatic void model_in(input logic [47:0] d);
        cplx_t c = d;
        exp_t  e;
        if (mbin < 512) begin
            e.d0   = ref_pow(c, 0);
            e.d16  = ref_pow(c, 16);
            e.bin  = bin_t'(mbin);
            e.last = (mbin == 511);
            exp_q.push_back(e);
        end
        mbin = (mbin + 1) % 1024;
    endfunction

    function automatic logic [47:0] rand_word();
        cplx_t c;
        if ($urandom_range(0, 1) == 1) begin
            c.re = 24'($urandom);
            c.im = 24'($urandom);
        end else begin
            c.re = 24'($urandom_range(0, 131071)) - 24'd65536;
            c.im = 24'($urandom_range(0, 131071)) - 24'd65536;
        end
        return c;
    endfunction

    // Drives one cycle from a negedge and records what the DUT shows before the next posedge.
    task automatic step(input logic v, input logic [47:0] d, input logic r, output obs_t o);
        din_a.valid  = v;
        din_a.data   = d;
        dout_a.ready = r;
        #1;
        o.in_hs  = v && din_a.ready && !reset;
        o.out_hs = dout_a.valid && r && !reset;
        o.valid  = dout_a.valid;
        o.dready = din_a.ready;
        o.d0     = dout_a.data;
        o.d16    = dout_b.data;
        o.bin    = bin_a;
        o.last   = last_a;
`ifdef FFT_POWER_PEAK_EN
        o.pv     = pv_a;
        o.pbin0  = pbin_a;
        o.pbin16 = pbin_b;
        o.pp0    = pp_a;
        o.pp16   = pp_b;
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        din_a.valid  = 1'b0;
        din_a.data   = '0;
        dout_a.ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mbin  = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (dout_a.valid !== 1'b0 || dout_a.data !== 32'd0 || dout_b.data !== 32'd0 || bin_a !== '0 || last_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b d0=%h d16=%h bin=%0d last=%b, want all zero", dout_a.valid, dout_a.data, dout_b.data, bin_a, last_a);
        end
        n_checks++;
        if (din_a.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_din_ready: got %b, want 1", din_a.ready);
        end
        @(negedge clk);
    endtask

    task automatic test_latency();
        obs_t  o;
        cplx_t c;
        c.re = 24'sd3;
        c.im = -24'sd4;
        step(1'b1, c, 1'b1, o);
        n_checks++;
        if (o.in_hs !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_accept: got in_hs=%b, want 1", o.in_hs);
        end
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, '0, 1'b1, o);
            n_checks++;
            if (o.valid !== (k == 3)) begin
                n_fail++;
                $display("FAIL latency_valid_cycle%0d: got %b, want %b", k, o.valid, (k == 3));
            end
        end
        n_checks++;
        if (o.d0 !== 32'd25 || o.d16 !== 32'd0 || o.bin !== bin_t'(0) || o.last !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_value: got d0=%0d d16=%0d bin=%0d last=%b, want 25 0 0 0", o.d0, o.d16, o.bin, o.last);
        end
    endtask

    task automatic test_saturation();
        obs_t  o;
        cplx_t c;
        bit    seen = 0;
        c.re = 24'sh800000;
        c.im = 24'sh800000;
        step(1'b1, c, 1'b1, o);
        for (int k = 0; k < 6 && !seen; k++) begin
            step(1'b0, '0, 1'b1, o);
            if (o.valid) begin
                seen = 1;
                n_checks++;
                if (o.d0 !== 32'hFFFF_FFFF || o.d16 !== 32'h8000_0000 || o.bin !== bin_t'(1)) begin
                    n_fail++;
                    $display("FAIL saturation: got d0=%h d16=%h bin=%0d, want ffffffff 80000000 1", o.d0, o.d16, o.bin);
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL saturation_timeout: got no output, want one sample");
        end
    endtask

    task automatic test_full_frame();
        obs_t        o;
        exp_t        e;
        logic [47:0] d;
        int unsigned got = 0, lasts = 0;
        do_reset();
        for (int c = 0; c < 1030; c++) begin
            d = (c < 1024) ? {24'd0, 24'(c)} : 48'd0;
            step(c < 1024, d, 1'b1, o);
            if (o.out_hs) begin
                got++;
                if (o.last) lasts++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_extra: got bin=%0d d0=%0d, want no output", o.bin, o.d0);
                end else begin
                    e = exp_q.pop_front();
                    if (o.d0 !== e.d0 || o.d16 !== e.d16 || o.bin !== e.bin || o.last !== e.last) begin
                        n_fail++;
                        $display("FAIL frame_sample: got d0=%0d d16=%0d bin=%0d last=%b, want %0d %0d %0d %b", o.d0, o.d16, o.bin, o.last, e.d0, e.d16, e.bin, e.last);
                    end
                end
            end
            if (o.in_hs) model_in(d);
        end
        n_checks++;
        if (got != 512 || lasts != 1) begin
            n_fail++;
            $display("FAIL frame_count: got outputs=%0d lasts=%0d, want 512 1", got, lasts);
        end
        n_checks++;
        if (mbin != 0) begin
            n_fail++;
            $display("FAIL frame_consumed: got model position %0d, want 0 after 1024 inputs", mbin);
        end
    endtask

    task automatic test_backpressure();
        obs_t        o, prev;
        exp_t        e;
        logic [47:0] d;
        logic        v, r, prev_r = 1'b1;
        bit          have_prev = 0;
        for (int c = 0; c < 2600; c++) begin
            v = (c < 2400) && ($urandom_range(0, 99) < 70);
            r = (c >= 2400) || ($urandom_range(0, 99) < 30);
            d = rand_word();
            step(v, d, r, o);
            n_checks++;
            if (o.dready !== (!o.valid || r)) begin
                n_fail++;
                $display("FAIL bp_din_ready: got %b, want %b (valid=%b ready=%b)", o.dready, (!o.valid || r), o.valid, r);
            end
            if (have_prev && prev.valid && !prev_r) begin
                n_checks++;
                if (o.valid !== 1'b1 || o.d0 !== prev.d0 || o.d16 !== prev.d16 || o.bin !== prev.bin || o.last !== prev.last) begin
                    n_fail++;
                    $display("FAIL bp_stall_hold: got valid=%b d0=%h bin=%0d, want 1 %h %0d", o.valid, o.d0, o.bin, prev.d0, prev.bin);
                end
            end
            if (o.out_hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: got bin=%0d d0=%h, want no output", o.bin, o.d0);
                end else begin
                    e = exp_q.pop_front();
                    if (o.d0 !== e.d0 || o.d16 !== e.d16 || o.bin !== e.bin || o.last !== e.last) begin
                        n_fail++;
                        $display("FAIL bp_sample: got d0=%h d16=%h bin=%0d last=%b, want %h %h %0d %b", o.d0, o.d16, o.bin, o.last, e.d0, e.d16, e.bin, e.last);
                    end
                end
            end
            if (o.in_hs) model_in(d);
            prev      = o;
            prev_r    = r;
            have_prev = 1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_lost: got %0d samples still pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_t        o;
        exp_t        e;
        logic [47:0] d;
        int unsigned got = 0;
        do_reset();
        while (mbin < 300) begin
            d = rand_word();
            step(1'b1, d, 1'b1, o);
            if (o.out_hs && exp_q.size() != 0) void'(exp_q.pop_front());
            if (o.in_hs) model_in(d);
        end
        reset = 1'b1;
        step(1'b1, rand_word(), 1'b1, o);
        reset = 1'b0;
        exp_q.delete();
        mbin = 0;
        for (int c = 0; c < 526; c++) begin
            d = rand_word();
            step(c < 520, d, 1'b1, o);
            if (o.out_hs) begin
                got++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rst_mid_stale: got bin=%0d d0=%h, want no output", o.bin, o.d0);
                end else begin
                    e = exp_q.pop_front();
                    if (o.d0 !== e.d0 || o.d16 !== e.d16 || o.bin !== e.bin || o.last !== e.last) begin
                        n_fail++;
                        $display("FAIL rst_mid_sample: got d0=%h d16=%h bin=%0d last=%b, want %h %h %0d %b", o.d0, o.d16, o.bin, o.last, e.d0, e.d16, e.bin, e.last);
                    end
                end
            end
            if (o.in_hs) model_in(d);
        end
        n_checks++;
        if (got != 512) begin
            n_fail++;
            $display("FAIL rst_mid_count: got %0d outputs, want 512", got);
        end
    endtask

`ifdef FFT_POWER_PEAK_EN
    task automatic test_peak();
        obs_t        o;
        cplx_t       cw;
        logic [31:0] pw0[512];
        logic [31:0] pw16[512];
        int          best0 = -1, best16 = -1;
        int          last_step = -1, pulse_step = -1, pulses = 0;
        logic [31:0] got_pp0 = '0, got_pp16 = '0;
        bin_t        got_b0 = '0, got_b16 = '0;
        do_reset();
        for (int c = 0; c < 1030; c++) begin
            cw.im = '0;
            cw.re = (c == 0) ? 24'sd5000 : ((c == 37 || c == 80) ? 24'sd1000 : 24'sd0);
            if (c < 512) begin
                pw0[c]  = ref_pow(cw, 0);
                pw16[c] = ref_pow(cw, 16);
            end
            step(c < 1024, cw, 1'b1, o);
            if (o.out_hs && o.last) last_step = c;
            if (o.pv) begin
                pulses++;
                pulse_step = c;
                got_pp0    = o.pp0;
                got_pp16   = o.pp16;
                got_b0     = o.pbin0;
                got_b16    = o.pbin16;
            end
        end
        for (int b = 1; b < 512; b++) begin
            if (best0 < 0 || pw0[b] > pw0[best0]) best0 = b;
            if (best16 < 0 || pw16[b] > pw16[best16]) best16 = b;
        end
        n_checks++;
        if (pulses != 1 || last_step < 0 || pulse_step != last_step + 1) begin
            n_fail++;
            $display("FAIL peak_pulse: got pulses=%0d at step %0d, want 1 at step %0d", pulses, pulse_step, last_step + 1);
        end
        n_checks++;
        if (got_b0 !== bin_t'(best0) || got_pp0 !== pw0[best0] || best0 != 37 || got_pp0 !== 32'd1000000) begin
            n_fail++;
            $display("FAIL peak_shift0: got bin=%0d power=%0d, want %0d %0d", got_b0, got_pp0, best0, pw0[best0]);
        end
        n_checks++;
        if (got_b16 !== bin_t'(best16) || got_pp16 !== pw16[best16] || got_pp16 !== (32'd1000000 >> 16)) begin
            n_fail++;
            $display("FAIL peak_shift16: got bin=%0d power=%0d, want %0d %0d", got_b16, got_pp16, best16, pw16[best16]);
        end
    endtask
`endif

    initial begin
        din_a.valid  = 1'b0;
        din_a.data   = '0;
        dout_a.ready = 1'b1;
        test_reset();
        test_latency();
        test_saturation();
        test_full_frame();
        test_backpressure();
        test_reset_mid_frame();
`ifdef FFT_POWER_PEAK_EN
        test_peak();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
